decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage that sits between the fetch/IF-ID register and the execute stage. It splits each instruction word into register addresses, an immediate and EX/MEM/WB/branch control fields, and holds the result in an output pipeline register. A valid/ready handshake connects it to fetch and to execute. It also detects load-use hazards and inserts one bubble when needed, and it honours a branch flush.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_fields.sv | 101 ++++++++++
 rtl/decode_stage.sv | 118 +++++++++++
 tb/tb_decode_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control encodings and field offsets.
package decode_pkg;

  localparam int OPCODE_W = 5;
  localparam int FUNCT_W  = 4;
  localparam int EX_W     = 5;

  localparam logic [4:0] OP_ALU  = 5'b00110;
  localparam logic [4:0] OP_ALUI = 5'b00100;
  localparam logic [4:0] OP_LW   = 5'b00010;
  localparam logic [4:0] OP_SW   = 5'b00011;
  localparam logic [4:0] OP_BEZ  = 5'b10000;
  localparam logic [4:0] OP_BNEZ = 5'b01000;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_LOAD = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b10;
  localparam logic [1:0] BR_BNEZ = 2'b01;

  function automatic int rd_lsb();
    return OPCODE_W;
  endfunction

  function automatic int funct_lsb(input int rw);
    return OPCODE_W + rw;
  endfunction

  function automatic int rs1_lsb(input int rw);
    return OPCODE_W + rw + FUNCT_W;
  endfunction

  // rs2 and the immediate share their low bits.
  function automatic int rs2_lsb(input int rw);
    return OPCODE_W + 2 * rw + FUNCT_W;
  endfunction

  function automatic int imm_lsb(input int rw);
    return OPCODE_W + 2 * rw + FUNCT_W;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction splitter: fields, controls, source-usage flags.
// Unknown opcodes raise illegal_o only when DECODE_ILLEGAL_EN is defined.
module decode_fields
  import decode_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 12
) (
  input  logic [INSTR_W-1:0]    ins_i,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [IMM_W-1:0]      imm_o,
  output logic [EX_W-1:0]       ex_ctrl_o,
  output logic                  mem_ctrl_o,
  output logic [1:0]            wb_ctrl_o,
  output logic [1:0]            br_ctrl_o,
  output logic                  rs1_used_o,
  output logic                  rs2_used_o,
  output logic                  illegal_o
);

  localparam int RD_LSB    = rd_lsb();
  localparam int FUNCT_LSB = funct_lsb(REG_ADDR_W);
  localparam int RS1_LSB   = rs1_lsb(REG_ADDR_W);
  localparam int RS2_LSB   = rs2_lsb(REG_ADDR_W);
  localparam int IMM_LSB   = imm_lsb(REG_ADDR_W);

  if (IMM_LSB + IMM_W > INSTR_W) begin : g_bad_layout
    $error("decode_fields: instruction fields exceed INSTR_W");
  end

  logic [OPCODE_W-1:0]   opcode_s;
  logic [REG_ADDR_W-1:0] rd_f_s;
  logic [REG_ADDR_W-1:0] rs1_f_s;
  logic [REG_ADDR_W-1:0] rs2_f_s;
  logic [FUNCT_W-1:0]    funct_f_s;
  logic [IMM_W-1:0]      imm_f_s;
  logic                  unused_ins_s;

  assign opcode_s     = ins_i[OPCODE_W-1:0];
  assign rd_f_s       = ins_i[RD_LSB +: REG_ADDR_W];
  assign funct_f_s    = ins_i[FUNCT_LSB +: FUNCT_W];
  assign rs1_f_s      = ins_i[RS1_LSB +: REG_ADDR_W];
  assign rs2_f_s      = ins_i[RS2_LSB +: REG_ADDR_W];
  assign imm_f_s      = ins_i[IMM_LSB +: IMM_W];
  assign unused_ins_s = ^ins_i;

  // Opcode decode; anything not listed decodes to an all-zero NOP.
  always_comb begin
    rd_o       = {REG_ADDR_W{1'b0}};
    rs1_o      = {REG_ADDR_W{1'b0}};
    rs2_o      = {REG_ADDR_W{1'b0}};
    imm_o      = {IMM_W{1'b0}};
    ex_ctrl_o  = {EX_W{1'b0}};
    mem_ctrl_o = 1'b0;
    wb_ctrl_o  = WB_NONE;
    br_ctrl_o  = BR_NONE;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_s)
      OP_ALU: begin
        rd_o = rd_f_s; rs1_o = rs1_f_s; rs2_o = rs2_f_s;
        ex_ctrl_o = {1'b0, funct_f_s}; wb_ctrl_o = WB_ALU;
        rs1_used_o = 1'b1; rs2_used_o = 1'b1;
      end
      OP_ALUI: begin
        rd_o = rd_f_s; rs1_o = rs1_f_s; imm_o = imm_f_s;
        ex_ctrl_o = {1'b1, funct_f_s}; wb_ctrl_o = WB_ALU;
        rs1_used_o = 1'b1;
      end
      OP_LW: begin
        rd_o = rd_f_s; rs1_o = rs1_f_s; rs2_o = rs2_f_s;
        wb_ctrl_o = WB_LOAD;
        rs1_used_o = 1'b1; rs2_used_o = 1'b1;
      end
      OP_SW: begin
        rs1_o = rs1_f_s; rs2_o = rs2_f_s; mem_ctrl_o = 1'b1;
        rs1_used_o = 1'b1; rs2_used_o = 1'b1;
      end
      OP_BEZ: begin
        rs1_o = rs1_f_s; imm_o = imm_f_s; br_ctrl_o = BR_BEZ;
        rs1_used_o = 1'b1;
      end
      OP_BNEZ: begin
        rs1_o = rs1_f_s; imm_o = imm_f_s; br_ctrl_o = BR_BNEZ;
        rs1_used_o = 1'b1;
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        illegal_o = 1'b1;
`else
        illegal_o = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, load-use stall and flush.
// Optional feature: DECODE_ILLEGAL_EN flags unknown opcodes on the illegal output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 12,
  parameter int PC_W       = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_ins,
  input  logic [PC_W-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [IMM_W-1:0]      imm,
  output logic [EX_W-1:0]       ex_ctrl,
  output logic                  mem_ctrl,
  output logic [1:0]            wb_ctrl,
  output logic [1:0]            br_ctrl,
  output logic                  illegal
);

  logic [REG_ADDR_W-1:0] dec_rd_s, dec_rs1_s, dec_rs2_s;
  logic [IMM_W-1:0]      dec_imm_s;
  logic [EX_W-1:0]       dec_ex_s;
  logic                  dec_mem_s, dec_rs1_used_s, dec_rs2_used_s, dec_ill_s;
  logic [1:0]            dec_wb_s, dec_br_s;

  logic                  valid_q, valid_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [IMM_W-1:0]      imm_q, imm_d;
  logic [EX_W-1:0]       ex_q, ex_d;
  logic                  mem_q, mem_d, ill_q, ill_d;
  logic [1:0]            wb_q, wb_d, br_q, br_d;
  logic                  hazard_s, ready_s;

  decode_fields #(
    .INSTR_W    (INSTR_W),
    .REG_ADDR_W (REG_ADDR_W),
    .IMM_W      (IMM_W)
  ) u_fields (
    .ins_i      (in_ins),
    .rd_o       (dec_rd_s),
    .rs1_o      (dec_rs1_s),
    .rs2_o      (dec_rs2_s),
    .imm_o      (dec_imm_s),
    .ex_ctrl_o  (dec_ex_s),
    .mem_ctrl_o (dec_mem_s),
    .wb_ctrl_o  (dec_wb_s),
    .br_ctrl_o  (dec_br_s),
    .rs1_used_o (dec_rs1_used_s),
    .rs2_used_o (dec_rs2_used_s),
    .illegal_o  (dec_ill_s)
  );

  // A held load is recognised by its load write-back encoding.
  assign hazard_s = valid_q && (wb_q == WB_LOAD) && (rd_q != {REG_ADDR_W{1'b0}}) && in_valid &&
                    ((dec_rs1_used_s && (dec_rs1_s == rd_q)) ||
                     (dec_rs2_used_s && (dec_rs2_s == rd_q)));
  assign ready_s  = flush || ((!valid_q || out_ready) && !hazard_s);

  // Next-state: flush beats transfer-in, which beats drain; otherwise hold.
  always_comb begin
    valid_d = valid_q; pc_d = pc_q; rd_d = rd_q; rs1_d = rs1_q; rs2_d = rs2_q;
    imm_d = imm_q; ex_d = ex_q; mem_d = mem_q; wb_d = wb_q; br_d = br_q; ill_d = ill_q;
    if (flush) begin
      valid_d = 1'b0; ex_d = {EX_W{1'b0}}; mem_d = 1'b0;
      wb_d = WB_NONE; br_d = BR_NONE; ill_d = 1'b0;
    end else if (in_valid && ready_s) begin
      valid_d = 1'b1; pc_d = in_pc; rd_d = dec_rd_s; rs1_d = dec_rs1_s; rs2_d = dec_rs2_s;
      imm_d = dec_imm_s; ex_d = dec_ex_s; mem_d = dec_mem_s; wb_d = dec_wb_s;
      br_d = dec_br_s; ill_d = dec_ill_s;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0; ex_d = {EX_W{1'b0}}; mem_d = 1'b0;
      wb_d = WB_NONE; br_d = BR_NONE;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0; pc_q <= {PC_W{1'b0}};
      rd_q <= {REG_ADDR_W{1'b0}}; rs1_q <= {REG_ADDR_W{1'b0}}; rs2_q <= {REG_ADDR_W{1'b0}};
      imm_q <= {IMM_W{1'b0}}; ex_q <= {EX_W{1'b0}}; mem_q <= 1'b0;
      wb_q <= WB_NONE; br_q <= BR_NONE; ill_q <= 1'b0;
    end else begin
      valid_q <= valid_d; pc_q <= pc_d; rd_q <= rd_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
      imm_q <= imm_d; ex_q <= ex_d; mem_q <= mem_d; wb_q <= wb_d; br_q <= br_d;
      ill_q <= ill_d;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;
  assign ex_ctrl   = ex_q;
  assign mem_ctrl  = mem_q;
  assign wb_ctrl   = wb_q;
  assign br_ctrl   = br_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Table-driven bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, mem_ctrl, illegal;
  logic [31:0] in_ins;
  logic [8:0]  in_pc, out_pc;
  logic [2:0]  rd, rs1, rs2;
  logic [11:0] imm;
  logic [4:0]  ex_ctrl;
  logic [1:0]  wb_ctrl, br_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .br_ctrl(br_ctrl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;   logic [31:0] ins; logic [8:0] pc; logic ordy; logic fl;
    logic        rdy;  logic ov;  logic chk;
    logic [8:0]  e_pc; logic [2:0] e_rd; logic [2:0] e_rs1; logic [2:0] e_rs2;
    logic [11:0] e_imm; logic [4:0] e_ex; logic e_mem; logic [1:0] e_wb;
    logic [1:0]  e_br; logic e_ill;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] r,
                                     input logic [3:0] fn, input logic [2:0] s1,
                                     input logic [11:0] hi);
    return {5'b00000, hi, s1, fn, r, op};
  endfunction

  function automatic vec_t v(input logic iv, input logic [31:0] ins, input logic [8:0] pc,
                             input logic ordy, input logic fl, input logic rdy,
                             input logic ov, input logic chk, input logic [8:0] e_pc,
                             input logic [2:0] e_rd, input logic [2:0] e_rs1,
                             input logic [2:0] e_rs2, input logic [11:0] e_imm,
                             input logic [4:0] e_ex, input logic e_mem,
                             input logic [1:0] e_wb, input logic [1:0] e_br,
                             input logic e_ill);
    vec_t t;
    t.iv = iv; t.ins = ins; t.pc = pc; t.ordy = ordy; t.fl = fl; t.rdy = rdy;
    t.ov = ov; t.chk = chk; t.e_pc = e_pc; t.e_rd = e_rd; t.e_rs1 = e_rs1;
    t.e_rs2 = e_rs2; t.e_imm = e_imm; t.e_ex = e_ex; t.e_mem = e_mem;
    t.e_wb = e_wb; t.e_br = e_br; t.e_ill = e_ill;
    return t;
  endfunction

  // Data fields are masked when chk = 0 (bubbles only define valid and controls).
  function automatic logic [41:0] pack(input logic ov, input logic [8:0] p,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [11:0] im,
                                       input logic [4:0] ex, input logic m,
                                       input logic [1:0] wb, input logic [1:0] br,
                                       input logic il, input logic chk);
    if (chk) return {ov, p, a, b, c, im, ex, m, wb, br, il};
    else     return {ov, 9'd0, 3'd0, 3'd0, 3'd0, 12'd0, ex, m, wb, br, il};
  endfunction

  function automatic logic [41:0] act(input logic chk);
    return pack(out_valid, out_pc, rd, rs1, rs2, imm, ex_ctrl, mem_ctrl, wb_ctrl,
                br_ctrl, illegal, chk);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [41:0] got,
                     input logic [41:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  logic [31:0] a1, dep, x_ins;

  initial begin
    a1    = 32'h0000_4326;
    dep   = mk(5'b00110, 3'd4, 4'h1, 3'd2, 12'h001);
    x_ins = mk(5'b00100, 3'd5, 4'h2, 3'd3, 12'h0A5);
    //          iv   ins                               pc      ordy  fl    rdy   ov    chk   e_pc    rd    rs1   rs2   imm       ex      mem   wb     br     ill
    vecs[0]  = v(1'b1, a1,                               9'h010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h010, 3'd1, 3'd4, 3'd0, 12'h000, 5'h03, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[1]  = v(1'b1, 32'h0000_8A24,                    9'h011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h011, 3'd1, 3'd0, 3'd0, 12'h001, 5'h1A, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[2]  = v(1'b1, mk(5'b00010,3'd2,4'h0,3'd3,12'h005), 9'h012, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h012, 3'd2, 3'd3, 3'd5, 12'h000, 5'h00, 1'b0, 2'b11, 2'b00, 1'b0);
    vecs[3]  = v(1'b1, dep,                              9'h013, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 3'd0, 3'd0, 12'h000, 5'h00, 1'b0, 2'b00, 2'b00, 1'b0);
    vecs[4]  = v(1'b1, dep,                              9'h013, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h013, 3'd4, 3'd2, 3'd1, 12'h000, 5'h01, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[5]  = v(1'b1, mk(5'b00010,3'd3,4'h0,3'd1,12'h000), 9'h014, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h014, 3'd3, 3'd1, 3'd0, 12'h000, 5'h00, 1'b0, 2'b11, 2'b00, 1'b0);
    vecs[6]  = v(1'b1, mk(5'b10000,3'd0,4'h0,3'd0,12'h013), 9'h015, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h015, 3'd0, 3'd0, 3'd0, 12'h013, 5'h00, 1'b0, 2'b00, 2'b10, 1'b0);
    vecs[7]  = v(1'b1, mk(5'b00010,3'd0,4'h0,3'd5,12'h002), 9'h016, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h016, 3'd0, 3'd5, 3'd2, 12'h000, 5'h00, 1'b0, 2'b11, 2'b00, 1'b0);
    vecs[8]  = v(1'b1, mk(5'b00110,3'd6,4'h7,3'd0,12'h000), 9'h018, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h018, 3'd6, 3'd0, 3'd0, 12'h000, 5'h07, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[9]  = v(1'b1, x_ins,                            9'h019, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h018, 3'd6, 3'd0, 3'd0, 12'h000, 5'h07, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = v(1'b1, x_ins,                            9'h019, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h019, 3'd5, 3'd3, 3'd0, 12'h0A5, 5'h12, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[13] = v(1'b1, mk(5'b00011,3'd7,4'h0,3'd6,12'h004), 9'h01A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h01A, 3'd0, 3'd6, 3'd4, 12'h000, 5'h00, 1'b1, 2'b00, 2'b00, 1'b0);
    vecs[14] = v(1'b1, mk(5'b01000,3'd0,4'h0,3'd1,12'h0F0), 9'h01B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 3'd0, 3'd0, 3'd0, 12'h000, 5'h00, 1'b0, 2'b00, 2'b00, 1'b0);
    vecs[15] = v(1'b0, 32'h0000_0000,                    9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 3'd0, 3'd0, 3'd0, 12'h000, 5'h00, 1'b0, 2'b00, 2'b00, 1'b0);
    vecs[16] = v(1'b1, mk(5'h1F,3'd3,4'h5,3'd2,12'h006),   9'h020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h020, 3'd0, 3'd0, 3'd0, 12'h000, 5'h00, 1'b0, 2'b00, 2'b00, ILL_EN);
    vecs[17] = v(1'b1, a1,                               9'h021, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h021, 3'd1, 3'd4, 3'd0, 12'h000, 5'h03, 1'b0, 2'b01, 2'b00, 1'b0);
    vecs[18] = v(1'b0, 32'h0000_0000,                    9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 3'd0, 3'd0, 3'd0, 12'h000, 5'h00, 1'b0, 2'b00, 2'b00, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_ins = 32'd0; in_pc = 9'd0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset", 0, act(1'b1), 42'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_ins = vecs[i].ins; in_pc = vecs[i].pc;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #2;
      cmp("in_ready", i, {41'd0, in_ready}, {41'd0, vecs[i].rdy});
      @(posedge clk);
      #1;
      cmp("out", i, act(vecs[i].chk),
          pack(vecs[i].ov, vecs[i].e_pc, vecs[i].e_rd, vecs[i].e_rs1, vecs[i].e_rs2,
               vecs[i].e_imm, vecs[i].e_ex, vecs[i].e_mem, vecs[i].e_wb, vecs[i].e_br,
               vecs[i].e_ill, vecs[i].chk));
    end

    // Asynchronous reset in the middle of a cycle drops the held instruction.
    @(negedge clk);
    in_valid = 1'b1; in_ins = a1; in_pc = 9'h030; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    cmp("pre_async_rst", 0, {41'd0, out_valid}, {41'd0, 1'b1});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst", 0, act(1'b1), 42'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
